// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings and debounce default for the stopwatch control stage
package stopwatch_pkg;
    localparam int DB_CYCLES_DEFAULT = 1000000;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: buttons and counter digits in, counter control and display digits out
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic [3:0] q1_in;
    logic [3:0] q10_in;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] disp_d1;
    logic [3:0] disp_d10;
    logic [1:0] state_o;
    modport master (
        input  btn_ss, btn_clr, btn_lap, q1_in, q10_in,
        output cnt_en, cnt_clr, disp_d1, disp_d10, state_o
    );
    modport slave (
        output btn_ss, btn_clr, btn_lap, q1_in, q10_in,
        input  cnt_en, cnt_clr, disp_d1, disp_d10, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw button and pulses press on each accepted rising level
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_press <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end
    assign level = r_level;
    assign press = r_press;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/pause/clear/lap FSM driving the 0-99 counter and
// a live-or-frozen digit feed to the display path
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    stopwatch_ctrl_if.master bus
);
    logic   w_p_ss, w_p_clr, w_p_lap;
    logic   w_clr, w_ss, w_lap;
    logic   w_clr_req, w_latch;
    state_t r_state, w_next;
    logic   r_en, r_clr;
    logic [3:0] r_lap1, r_lap10, r_d1, r_d10;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_ss), .level(), .press(w_p_ss));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_clr), .level(), .press(w_p_clr));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_lap), .level(), .press(w_p_lap));

    // one press per cycle: clr beats ss beats lap, losers are dropped
    assign w_clr = w_p_clr;
    assign w_ss  = w_p_ss & ~w_p_clr;
    assign w_lap = w_p_lap & ~w_p_clr & ~w_p_ss;

    always_comb begin
        w_next    = r_state;
        w_clr_req = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr_req = w_clr;
                w_next    = w_ss ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                w_latch = w_lap;
                w_next  = w_ss ? ST_PAUSE : w_lap ? ST_LAP : ST_RUN;
            end
            ST_LAP:  w_next = w_ss ? ST_PAUSE : w_lap ? ST_RUN : ST_LAP;
            default: begin
                w_clr_req = w_clr;
                w_next    = w_clr ? ST_IDLE : w_ss ? ST_RUN : ST_PAUSE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_lap1  <= '0;
            r_lap10 <= '0;
            r_d1    <= '0;
            r_d10   <= '0;
        end else begin
            r_state <= w_next;
            r_en    <= (w_next == ST_RUN) || (w_next == ST_LAP);
            r_clr   <= w_clr_req;
            if (w_latch) begin
                r_lap1  <= bus.q1_in;
                r_lap10 <= bus.q10_in;
            end
            r_d1  <= (r_state == ST_LAP) ? r_lap1 : bus.q1_in;
            r_d10 <= (r_state == ST_LAP) ? r_lap10 : bus.q10_in;
        end
    end

    assign bus.cnt_en   = r_en;
    assign bus.cnt_clr  = r_clr;
    assign bus.disp_d1  = r_d1;
    assign bus.disp_d10 = r_d10;
    assign bus.state_o  = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of debounce timing, FSM transitions, lap freeze and clear
module tb_stopwatch_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    stopwatch_ctrl_if sw ();
    stopwatch_ctrl #(.DB_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(sw));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       sw.btn_ss  = v;
            1:       sw.btn_clr = v;
            default: sw.btn_lap = v;
        endcase
    endtask

    // hold long enough to debounce, then release and let the release settle
    task automatic push(input int b);
        set_btn(b, 1'b1);
        cyc(10);
        set_btn(b, 1'b0);
        cyc(10);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic en, input logic clr,
                           input logic [3:0] d10, input logic [3:0] d1);
        chk({tag, "_state"}, 8'(sw.state_o), 8'(st));
        chk({tag, "_en"}, 8'(sw.cnt_en), 8'(en));
        chk({tag, "_clr"}, 8'(sw.cnt_clr), 8'(clr));
        chk({tag, "_d10"}, 8'(sw.disp_d10), 8'(d10));
        chk({tag, "_d1"}, 8'(sw.disp_d1), 8'(d1));
    endtask

    initial begin
        sw.btn_ss = 0; sw.btn_clr = 0; sw.btn_lap = 0;
        sw.q1_in = 0; sw.q10_in = 0;
        cyc(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk_all("idle", 2'd0, 1'b0, 1'b0, 4'd0, 4'd0);
        end

        // first start: press lands 6 cycles after the raw edge, state one cycle later
        set_btn(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("ss_wait_state", 8'(sw.state_o), 8'd0);
        end
        cyc(1);
        chk("ss_run_state", 8'(sw.state_o), 8'd1);
        chk("ss_run_en", 8'(sw.cnt_en), 8'd1);
        cyc(3);
        set_btn(0, 1'b0);
        cyc(10);
        chk("ss_release_state", 8'(sw.state_o), 8'd1);

        push(0);
        chk("ss_pause_state", 8'(sw.state_o), 8'd2);
        chk("ss_pause_en", 8'(sw.cnt_en), 8'd0);

        // 3-cycle glitch must not debounce
        set_btn(0, 1'b1);
        cyc(3);
        set_btn(0, 1'b0);
        cyc(10);
        chk("glitch_state", 8'(sw.state_o), 8'd2);

        // lap freeze in RUN
        push(0);
        chk("resume_state", 8'(sw.state_o), 8'd1);
        sw.q10_in = 4'd4; sw.q1_in = 4'd2;
        push(2);
        sw.q10_in = 4'd5; sw.q1_in = 4'd7;
        cyc(2);
        chk_all("lap_hold", 2'd3, 1'b1, 1'b0, 4'd4, 4'd2);
        sw.q10_in = 4'd0; sw.q1_in = 4'd0;
        cyc(2);
        chk_all("lap_wrap", 2'd3, 1'b1, 1'b0, 4'd4, 4'd2);
        sw.q10_in = 4'd5; sw.q1_in = 4'd7;
        set_btn(2, 1'b1);
        cyc(7);
        chk_all("unlap_edge", 2'd1, 1'b1, 1'b0, 4'd4, 4'd2);
        cyc(1);
        chk_all("unlap_live", 2'd1, 1'b1, 1'b0, 4'd5, 4'd7);
        cyc(2);
        set_btn(2, 1'b0);
        cyc(10);

        // clr ignored in RUN
        set_btn(1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("clr_run_clr", 8'(sw.cnt_clr), 8'd0);
        end
        set_btn(1, 1'b0);
        cyc(10);
        chk("clr_run_state", 8'(sw.state_o), 8'd1);

        // clr in PAUSE: exactly one cnt_clr cycle
        push(0);
        chk("pause2_state", 8'(sw.state_o), 8'd2);
        set_btn(1, 1'b1);
        cyc(6);
        chk("clr_pre", 8'(sw.cnt_clr), 8'd0);
        cyc(1);
        chk("clr_pulse", 8'(sw.cnt_clr), 8'd1);
        chk("clr_idle_state", 8'(sw.state_o), 8'd0);
        cyc(1);
        chk("clr_post", 8'(sw.cnt_clr), 8'd0);
        cyc(2);
        set_btn(1, 1'b0);
        cyc(10);

        // simultaneous clr+ss in PAUSE: clr wins, ss dropped
        push(0);
        push(0);
        chk("pause3_state", 8'(sw.state_o), 8'd2);
        set_btn(0, 1'b1);
        set_btn(1, 1'b1);
        cyc(7);
        chk("both_clr", 8'(sw.cnt_clr), 8'd1);
        chk("both_state", 8'(sw.state_o), 8'd0);
        cyc(3);
        set_btn(0, 1'b0);
        set_btn(1, 1'b0);
        cyc(10);
        chk("both_after_state", 8'(sw.state_o), 8'd0);
        chk("both_after_en", 8'(sw.cnt_en), 8'd0);

        // ss from LAP goes to PAUSE
        push(0);
        push(2);
        chk("lap2_state", 8'(sw.state_o), 8'd3);
        push(0);
        chk("lap_ss_state", 8'(sw.state_o), 8'd2);
        chk("lap_ss_en", 8'(sw.cnt_en), 8'd0);

        // reset mid-LAP
        push(0);
        push(2);
        chk("lap3_state", 8'(sw.state_o), 8'd3);
        reset = 1'b1;
        cyc(1);
        chk_all("rst_lap", 2'd0, 1'b0, 1'b0, 4'd0, 4'd0);
        reset = 1'b0;
        cyc(2);
        chk_all("rst_after", 2'd0, 1'b0, 1'b0, 4'd5, 4'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
